// File: rtl/keypad_scanner.sv
// keypad_scanner: one-hot row scanner with whole-frame debounce, ghost rejection
// and press/release events; define KEYPAD_SCANNER_REPEAT_EN for auto-repeat.
module keypad_scanner #(
   parameter int ROWS          = 4,
   parameter int COLS          = 3,
   parameter int SCAN_DIV      = 4,
   parameter int DEBOUNCE      = 3,
   parameter int REPEAT_DELAY  = 32,
   parameter int REPEAT_PERIOD = 8,
   localparam int CODE_W       = $clog2(ROWS*COLS+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [COLS-1:0]   key_col,
   output logic [ROWS-1:0]   key_row,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_press,
   output logic              key_release,
   output logic              key_multi
);

   localparam int RW = $clog2(ROWS);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE+1);

   localparam logic [CODE_W-1:0] NONE       = '1;
   localparam logic [CODE_W-1:0] COLS_C     = CODE_W'(COLS);
   localparam logic [RW-1:0]     ROW_LAST   = RW'(ROWS-1);
   localparam logic [DW-1:0]     DWELL_LAST = DW'(SCAN_DIV-1);
   localparam logic [CW-1:0]     DEB_MAX    = CW'(DEBOUNCE);
   localparam logic [ROWS-1:0]   ROW0       = {1'b1, {(ROWS-1){1'b0}}};

   if (ROWS < 2 || COLS < 2 || SCAN_DIV < 2 || DEBOUNCE < 1 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("keypad_scanner: parameter out of range");
   end

   typedef enum logic {
      IDLE,
      HELD
   } state_t;

   state_t            state_q, state_d;
   logic              run_q;
   logic [RW-1:0]     row_q, row_d;
   logic [DW-1:0]     dwell_q, dwell_d;
   logic [1:0]        hits_q, hits_d;
   logic [CODE_W-1:0] idx_q, idx_d;
   logic [CODE_W-1:0] cand_q, cand_d;
   logic [CW-1:0]     dcnt_q, dcnt_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              valid_q, valid_d;
   logic              press_q, press_d;
   logic              rel_q, rel_d;
   logic              multi_q, multi_d;

   logic              sample;
   logic              frame_end;
   logic              stable;
   logic [1:0]        row_hits;
   logic [2:0]        hit_sum;
   logic [1:0]        tot_hits;
   logic [CODE_W-1:0] row_base;
   logic [CODE_W-1:0] row_idx;
   logic [CODE_W-1:0] tot_idx;
   logic [CODE_W-1:0] result;

`ifdef KEYPAD_SCANNER_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                            REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX+1);
   localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_PERIOD);

   logic [REP_W-1:0] rep_q, rep_d;
   logic [REP_W-1:0] rep_nx;
   logic [REP_W-1:0] rep_tgt;
   logic             first_q, first_d;
`endif

   assign key_row     = run_q ? (ROW0 >> row_q) : '0;
   assign key_code    = code_q;
   assign key_valid   = valid_q;
   assign key_press   = press_q;
   assign key_release = rel_q;
   assign key_multi   = multi_q;

   always_comb begin
      row_d     = row_q;
      dwell_d   = dwell_q;
      sample    = 1'b0;
      frame_end = 1'b0;
      if (run_q) begin
         if (dwell_q == DWELL_LAST) begin
            sample  = 1'b1;
            dwell_d = '0;
            if (row_q == ROW_LAST) begin
               frame_end = 1'b1;
               row_d     = '0;
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            dwell_d = dwell_q + 1'b1;
         end
      end
   end

   // hit count saturates at 2: only "none / one / many" matters
   always_comb begin
      row_base = CODE_W'(row_q) * COLS_C;
      row_hits = '0;
      row_idx  = '0;
      for (int c = 0; c < COLS; c++) begin
         if (key_col[COLS-1-c]) begin
            if (row_hits != 2'd2) begin
               row_hits = row_hits + 2'd1;
            end
            row_idx = row_base + CODE_W'(c);
         end
      end
   end

   always_comb begin
      hit_sum  = {1'b0, hits_q} + {1'b0, row_hits};
      tot_hits = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
      tot_idx  = (row_hits != 2'd0) ? row_idx : idx_q;
      result   = (tot_hits == 2'd1) ? tot_idx : NONE;
   end

   always_comb begin
      hits_d  = hits_q;
      idx_d   = idx_q;
      multi_d = multi_q;
      if (sample) begin
         hits_d = frame_end ? 2'd0 : tot_hits;
         idx_d  = frame_end ? '0 : tot_idx;
      end
      if (frame_end) begin
         multi_d = tot_hits[1];
      end
   end

   always_comb begin
      cand_d = cand_q;
      dcnt_d = dcnt_q;
      if (frame_end) begin
         if (result == cand_q) begin
            if (dcnt_q != DEB_MAX) begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end else begin
            cand_d = result;
            dcnt_d = CW'(1);
         end
      end
      stable = frame_end && (dcnt_d == DEB_MAX);
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      valid_d = valid_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
      rep_d   = rep_q;
      first_d = first_q;
      rep_nx  = rep_q + 1'b1;
      rep_tgt = first_q ? REP_DLY : REP_PER;
`endif
      unique case (state_q)
         IDLE: begin
            if (stable && cand_d != NONE) begin
               state_d = HELD;
               code_d  = cand_d;
               valid_d = 1'b1;
               press_d = 1'b1;
`ifdef KEYPAD_SCANNER_REPEAT_EN
               rep_d   = '0;
               first_d = 1'b1;
`endif
            end
         end
         HELD: begin
            if (stable && cand_d != code_q) begin
               state_d = IDLE;
               valid_d = 1'b0;
               rel_d   = 1'b1;
`ifdef KEYPAD_SCANNER_REPEAT_EN
               rep_d   = '0;
               first_d = 1'b1;
`endif
            end
`ifdef KEYPAD_SCANNER_REPEAT_EN
            else if (frame_end) begin
               rep_d = rep_nx;
               if (rep_nx == rep_tgt) begin
                  press_d = 1'b1;
                  rep_d   = '0;
                  first_d = 1'b0;
               end
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         run_q   <= 1'b0;
         row_q   <= '0;
         dwell_q <= '0;
         hits_q  <= '0;
         idx_q   <= '0;
         cand_q  <= NONE;
         dcnt_q  <= '0;
         code_q  <= NONE;
         valid_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         row_q   <= row_d;
         dwell_q <= dwell_d;
         hits_q  <= hits_d;
         idx_q   <= idx_d;
         cand_q  <= cand_d;
         dcnt_q  <= dcnt_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         multi_q <= multi_d;
      end
   end

`ifdef KEYPAD_SCANNER_REPEAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_q   <= '0;
         first_q <= 1'b1;
      end else begin
         rep_q   <= rep_d;
         first_q <= first_d;
      end
   end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboarded bench; a behavioural key matrix
// drives the column returns from the row strobes.
`timescale 1ns/1ps
module tb_keypad_scanner;

   localparam int ROWS   = 4;
   localparam int COLS   = 3;
   localparam int CODE_W = 4;
   localparam int F      = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [COLS-1:0]   key_col;
   logic [ROWS-1:0]   key_row;
   logic [CODE_W-1:0] key_code;
   logic              key_valid;
   logic              key_press;
   logic              key_release;
   logic              key_multi;

   logic [ROWS*COLS-1:0] keys = '0;
   int ecnt = -1;
   int nvec = 0;
   int nerr = 0;

   typedef struct {
      bit rel;
      int code;
      int t;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;

   keypad_scanner dut (
      .clk        (clk),
      .rst        (rst),
      .key_col    (key_col),
      .key_row    (key_row),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_press  (key_press),
      .key_release(key_release),
      .key_multi  (key_multi)
   );

   always #5 clk = ~clk;

   // edge index since reset release: frame n ends at ecnt == n*F
   always @(posedge clk) ecnt <= rst ? -1 : ecnt + 1;

   always_comb begin
      key_col = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (key_row[ROWS-1-r]) begin
            for (int c = 0; c < COLS; c++) begin
               if (keys[r*COLS+c]) key_col[COLS-1-c] = 1'b1;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0d)",
                  name, act, exp, ecnt);
      end
   endtask

   task automatic expect_ev(input bit rel, input int code, input int t);
      exp_q.push_back('{rel, code, t});
   endtask

   task automatic goto_t(input int t);
      int guard;
      guard = 0;
      while (ecnt < t) begin
         @(negedge clk);
         guard++;
         if (guard > 3000) begin
            nvec++;
            nerr++;
            $display("FAIL goto_timeout: at t=%0d, wanted t=%0d", ecnt, t);
            break;
         end
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].t < ecnt) begin
         mon_e = exp_q.pop_front();
         nvec++;
         nerr++;
         $display("FAIL missed_event: rel=%0d code=%0d due t=%0d, now t=%0d",
                  mon_e.rel, mon_e.code, mon_e.t, ecnt);
      end
      if (key_press && key_release) begin
         nvec++;
         nerr++;
         $display("FAIL both_pulses: press and release at t=%0d", ecnt);
      end else if (key_press || key_release) begin
         nvec++;
         if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_event: rel=%0d code=%0d t=%0d",
                     key_release, key_code, ecnt);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.rel != key_release || mon_e.code != int'(key_code) ||
                mon_e.t != ecnt || key_valid != !mon_e.rel) begin
               nerr++;
               $display("FAIL event: got rel=%0d code=%0d t=%0d valid=%0d, expected rel=%0d code=%0d t=%0d valid=%0d",
                        key_release, key_code, ecnt, key_valid,
                        mon_e.rel, mon_e.code, mon_e.t, !mon_e.rel);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int m;
      rst  = 1'b1;
      keys = '0;
      repeat (2) @(negedge clk);
      chk("rst_key_row", key_row, 0);
      chk("rst_key_code", key_code, 15);
      chk("rst_key_valid", key_valid, 0);
      chk("rst_key_press", key_press, 0);
      chk("rst_key_release", key_release, 0);
      chk("rst_key_multi", key_multi, 0);
      rst = 1'b0;

      for (int t = 0; t < 2*F; t++) begin
         goto_t(t);
         chk("scan_key_row", key_row, 8 >> ((t/4) % 4));
      end
      chk("idle_valid", key_valid, 0);
      chk("idle_code", key_code, 15);
      chk("idle_multi", key_multi, 0);

      // clean press of key 4 (row 1, col 1) for 5 frames
      m = 2;
      goto_t(F*m);
      keys = 12'd1 << 4;
      expect_ev(1'b0, 4, F*(m+3));
      expect_ev(1'b1, 4, F*(m+8));
      goto_t(F*(m+2));
      chk("clean_pre_valid", key_valid, 0);
      goto_t(F*(m+3));
      chk("clean_valid", key_valid, 1);
      chk("clean_code", key_code, 4);
      goto_t(F*(m+5));
      keys = '0;
      goto_t(F*(m+7));
      chk("clean_hold_valid", key_valid, 1);
      goto_t(F*(m+8));
      chk("clean_rel_valid", key_valid, 0);
      chk("clean_rel_code", key_code, 4);
      m = m + 8;

      // bounce: 2 frames on, 1 off, 3 on
      goto_t(F*m);
      keys = 12'd1 << 7;
      goto_t(F*(m+2));
      keys = '0;
      goto_t(F*(m+3));
      keys = 12'd1 << 7;
      expect_ev(1'b0, 7, F*(m+6));
      goto_t(F*(m+5));
      chk("bounce_pre_valid", key_valid, 0);
      goto_t(F*(m+6));
      keys = '0;
      expect_ev(1'b1, 7, F*(m+9));
      goto_t(F*(m+9));
      m = m + 9;

      // two keys in row 0: ghost rejection
      goto_t(F*m);
      chk("multi_pre", key_multi, 0);
      keys = 12'b11;
      goto_t(F*(m+1));
      chk("multi_set", key_multi, 1);
      chk("multi_valid", key_valid, 0);
      goto_t(F*(m+4));
      chk("multi_held", key_multi, 1);
      chk("multi_held_valid", key_valid, 0);
      keys = '0;
      goto_t(F*(m+5));
      chk("multi_clear", key_multi, 0);
      m = m + 5;

      // key change 0 -> 11
      goto_t(F*m);
      keys = 12'd1;
      expect_ev(1'b0, 0, F*(m+3));
      goto_t(F*(m+3));
      keys = 12'd1 << 11;
      expect_ev(1'b1, 0, F*(m+6));
      expect_ev(1'b0, 11, F*(m+7));
      goto_t(F*(m+6));
      chk("chg_rel_code", key_code, 0);
      chk("chg_rel_valid", key_valid, 0);
      goto_t(F*(m+7));
      chk("chg_code", key_code, 11);
      chk("chg_valid", key_valid, 1);
      keys = '0;
      expect_ev(1'b1, 11, F*(m+10));
      goto_t(F*(m+10));
      m = m + 10;

      // press shorter than the debounce depth
      goto_t(F*m);
      keys = 12'd1 << 5;
      goto_t(F*(m+2));
      keys = '0;
      goto_t(F*(m+6));
      chk("short_valid", key_valid, 0);
      m = m + 6;

      // reset while a key is held
      goto_t(F*m);
      keys = 12'd1 << 4;
      expect_ev(1'b0, 4, F*(m+3));
      goto_t(F*(m+4) + 5);
      chk("rh_valid_before", key_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rh_valid", key_valid, 0);
      chk("rh_code", key_code, 15);
      chk("rh_press", key_press, 0);
      chk("rh_release", key_release, 0);
      chk("rh_key_row", key_row, 0);
      chk("rh_queue", exp_q.size(), 0);
      @(negedge clk);
      rst = 1'b0;

      // 48-frame hold from the first frame
      keys = 12'd1 << 4;
      expect_ev(1'b0, 4, F*3);
`ifdef KEYPAD_SCANNER_REPEAT_EN
      expect_ev(1'b0, 4, F*35);
      expect_ev(1'b0, 4, F*43);
`endif
      goto_t(F*3);
      chk("hold_code", key_code, 4);
      goto_t(F*48);
      chk("hold_valid", key_valid, 1);
      keys = '0;
      expect_ev(1'b1, 4, F*51);
      goto_t(F*54);
      chk("hold_end_valid", key_valid, 0);
      chk("final_queue", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner: drives one-hot row strobes, samples column returns, debounces whole-frame scan results, and reports a registered key code with one-cycle press/release events. It sits between the board keypad pins and the application control logic, and replaces the fixed 4x3, undebounced scanner with configurable geometry, dwell time, debounce depth, ghost/multi-key rejection and optional auto-repeat.

## Interface
- ROWS, 4, number of row strobes (>=2)
- COLS, 3, number of column returns (>=2)
- SCAN_DIV, 4, clock cycles each row is driven (>=2; last cycle is the sample cycle)
- DEBOUNCE, 3, consecutive identical frame results required to accept a change (>=1)
- REPEAT_DELAY, 32, frames held before first repeat (used only with repeat feature)
- REPEAT_PERIOD, 8, frames between repeats (used only with repeat feature)
- Derived: CODE_W = $clog2(ROWS*COLS+1); idle code = all ones (never a valid index)
- clk  in  1  system clock; one clock, all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- key_col  in  COLS  column returns, active-high; column c is key_col[COLS-1-c]
- key_row  out  ROWS  row strobes, one-hot active-high; row r is key_row[ROWS-1-r]
- key_code  out  CODE_W  accepted key index r*COLS+c; idle code when no key accepted since reset
- key_valid  out  1  level: a debounced key is currently held
- key_press  out  1  one-cycle pulse on accepted press (and repeats)
- key_release  out  1  one-cycle pulse on accepted release
- key_multi  out  1  level: last completed frame saw more than one key

## Operation
- Row scan: row counter 0..ROWS-1 and dwell counter 0..SCAN_DIV-1; key_row drives current row; wraps ROWS-1 -> 0 continuously.
- Sampling: key_col captured only in the last dwell cycle of each row; each asserted bit adds to the frame hit count and records index r*COLS+c.
- Frame result at end of row ROWS-1: exactly one hit -> KEY(index); zero hits -> NONE; two or more -> NONE with key_multi=1 (ghost rejection). key_multi updated every frame end, not debounced.
- Debounce: candidate register plus saturating counter; frame result equal to candidate -> counter+1 (saturate at DEBOUNCE); different -> candidate=result, counter=1. Candidate is "stable" when counter==DEBOUNCE.
- FSM states IDLE, HELD:
  - IDLE, stable KEY(k) -> key_code=k, key_valid=1, key_press pulse, -> HELD.
  - HELD, stable NONE or stable KEY(j), j!=k -> key_valid=0, key_release pulse, -> IDLE; key_code keeps k. A stable new key j then presses at the next frame end.
  - Otherwise hold state.
- key_press and key_release never assert in the same cycle.

## Timing
- Reset values: key_row=0, key_code=all ones, key_valid=0, key_press=0, key_release=0, key_multi=0; counters zero; FSM IDLE; candidate NONE, counter 0.
- First edge after rst deasserts: key_row = row 0 strobe.
- Frame length F = ROWS*SCAN_DIV cycles; frame-end decisions take effect on the edge ending the sample cycle of row ROWS-1; pulses last exactly that following cycle.
- Key present from frame start: key_press asserted DEBOUNCE frames later at frame end (default 3 frames = 48 cycles after the first frame start).
- Press shorter than DEBOUNCE consecutive frames: no event.
- rst mid-frame: next edge restores all reset values; partial frame and debounce history discarded; no release pulse emitted.

## Configuration
- KEYPAD_SCANNER_REPEAT_EN defined: in HELD, frame counter increments each frame end; at REPEAT_DELAY frames after press, then every REPEAT_PERIOD frames, key_press pulses again with key_code unchanged; counter cleared on leaving HELD.
- Not defined: exactly one key_press per hold; repeat counter not built; REPEAT_* ignored.

## Test plan
- Reset/scan: rst 2 cycles then release, no keys -> key_row 4'b1000,0100,0010,0001 each 4 cycles, repeating; all outputs at reset values.
- Clean press: hold key_col=3'b010 during row 1 strobe for 5 frames -> key_press one cycle at end of 3rd frame, key_code=4, key_valid=1; release -> key_release at 3rd empty frame end, key_code stays 4.
- Bounce: key present 2 frames, absent 1, present 3 -> single key_press, at end of final 3rd frame only.
- Multi-key: key_col=3'b110 during row 0 -> key_multi=1 at frame end, no key_press; key_valid stays 0.
- Key change: held code 0 switched to code 11 (row 3, col 2) -> key_release after 3 stable frames, key_press code 11 one frame later.
- Reset mid-hold: rst asserted while key_valid=1 -> next cycle key_valid=0, key_code=4'hf, no pulses; with KEYPAD_SCANNER_REPEAT_EN, 48-frame hold -> press at frame 3, repeats at frames 35 and 43.
